// File: rtl/phase_arb_pkg.sv
// Shared types and default sizing for the phase step arbiter.
package phase_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_NPHASE    = 7;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after `last`, wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);

    // rot_req[k] is the request (k+1) positions after last
    logic [NREQ-1:0] rot_req;
    logic [IW-1:0]   rot_idx [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign rot_idx[gi] = IW'((int'(last) + 1 + gi) % NREQ);
        assign rot_req[gi] = req[rot_idx[gi]];
    end

    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick          = '0;
                pick[rot_idx[k]] = 1'b1;
                idx           = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/phase_step_arbiter.sv
// Round-robin owner arbitration in front of a shared NPHASE ring step counter.
// Optional macro STEP_ERR_EN adds a sticky step_err output for steps from non-owners.
module phase_step_arbiter
    import phase_arb_pkg::*;
#(
    parameter  int NREQ      = DEF_NREQ,
    parameter  int NPHASE    = DEF_NPHASE,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int PW        = $clog2(NPHASE),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] step,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   phase,
    output logic            boundary,
    output logic            wrap,
`ifdef STEP_ERR_EN
    output logic            step_err,
`endif
    output logic            busy
);

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   last_reg, last_next;
    logic [BW-1:0]   burst_reg, burst_next;
    logic [PW-1:0]   phase_reg, phase_next;
    logic            wrap_reg, wrap_next;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            own_step;
    logic            at_last_phase;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .last (last_reg),
        .pick (pick_onehot),
        .idx  (pick_idx)
    );

    assign own_step      = step[owner_reg];
    assign at_last_phase = (phase_reg == PW'(NPHASE - 1));

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        burst_next = burst_reg;
        phase_next = phase_reg;
        wrap_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    gnt_next   = pick_onehot;
                    owner_next = pick_idx;
                    last_next  = pick_idx;
                    burst_next = '0;
                end
            end
            GRANT: begin
                if (own_step) begin
                    phase_next = at_last_phase ? '0 : phase_reg + 1'b1;
                    wrap_next  = at_last_phase;
                    burst_next = burst_reg + 1'b1;
                end
                // A releasing step still lands; the idle cycle that follows forces a grant gap
                if (!req[owner_reg] || (own_step && burst_reg == BW'(MAX_BURST - 1))) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            owner_reg <= '0;
            last_reg  <= IW'(NREQ - 1);
            burst_reg <= '0;
            phase_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            burst_reg <= burst_next;
            phase_reg <= phase_next;
            wrap_reg  <= wrap_next;
        end
    end

`ifdef STEP_ERR_EN
    logic step_err_reg;

    // gnt_reg is zero in IDLE, so every step there counts as illegal
    always_ff @(posedge clk) begin
        if (!rst) begin
            step_err_reg <= 1'b0;
        end else if (|(step & ~gnt_reg)) begin
            step_err_reg <= 1'b1;
        end
    end

    assign step_err = step_err_reg;
`endif

    assign gnt      = gnt_reg;
    assign phase    = phase_reg;
    assign wrap     = wrap_reg;
    assign busy     = (state_reg == GRANT);
    assign boundary = (phase_reg == '0) || at_last_phase;

endmodule

// File: tb/tb_phase_step_arbiter.sv
// Directed and short pseudo-random stimulus, checked every cycle against an ownership model.
module tb_phase_step_arbiter;

    localparam int NREQ      = 4;
    localparam int NPHASE    = 7;
    localparam int MAX_BURST = 4;
    localparam int PW        = $clog2(NPHASE);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] step = '0;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   phase;
    logic            boundary;
    logic            wrap;
    logic            busy;
`ifdef STEP_ERR_EN
    logic            step_err;
`endif

    phase_step_arbiter #(
        .NREQ      (NREQ),
        .NPHASE    (NPHASE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .step     (step),
        .gnt      (gnt),
        .phase    (phase),
        .boundary (boundary),
        .wrap     (wrap),
`ifdef STEP_ERR_EN
        .step_err (step_err),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner is -1 when nobody holds the sequencer
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_burst = 0;
    int m_phase = 0;
    bit m_wrap  = 1'b0;
    bit m_err   = 1'b0;
    int m_cand;
    bit m_found;

    always @(posedge clk) begin
        if (!rst) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_burst = 0;
            m_phase = 0;
            m_wrap  = 1'b0;
            m_err   = 1'b0;
        end else begin
            for (int j = 0; j < NREQ; j++)
                if (step[j] && j != m_owner) m_err = 1'b1;
            m_wrap = 1'b0;
            if (m_owner < 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    m_cand = (m_last + k) % NREQ;
                    if (!m_found && req[m_cand]) begin
                        m_found = 1'b1;
                        m_owner = m_cand;
                        m_last  = m_cand;
                        m_burst = 0;
                    end
                end
            end else begin
                if (step[m_owner]) begin
                    m_wrap  = (m_phase == NPHASE - 1);
                    m_phase = (m_phase + 1) % NPHASE;
                    m_burst = m_burst + 1;
                end
                if (!req[m_owner] || m_burst == MAX_BURST) m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("phase", 32'(phase), 32'(m_phase));
            check("boundary", 32'(boundary), 32'(m_phase == 0 || m_phase == NPHASE - 1));
            check("wrap", 32'(wrap), 32'(m_wrap));
            check("busy", 32'(busy), 32'(m_owner >= 0));
`ifdef STEP_ERR_EN
            check("step_err", 32'(step_err), 32'(m_err));
`endif
        end
    end

    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] s);
        req  = r;
        step = s;
        @(negedge clk);
    endtask

    logic [NREQ-1:0] rnd_req, rnd_step;

    initial begin
        // Reset state
        rst = 1'b0;
        cyc('0, '0);
        cyc('0, '0);
        chk_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_boundary", 32'(boundary), 32'd1);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Single requester, forced release after MAX_BURST steps
        cyc(4'b0010, 4'b0000);
        check("t2_gnt", 32'(gnt), 32'b0010);
        repeat (4) cyc(4'b0010, 4'b0010);
        check("t2_phase", 32'(phase), 32'd4);
        check("t2_release", 32'(gnt), 32'd0);
        cyc(4'b0010, 4'b0000);
        check("t2_regrant", 32'(gnt), 32'b0010);
        cyc(4'b0000, 4'b0000);
        check("t2_drop", 32'(gnt), 32'd0);

        // All requesting: rotation 0,1,2,3,0 with a gap between grants
        rst = 1'b0;
        cyc('0, '0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 4'b0000);
            check("t3_order", 32'(gnt), 32'd1 << (i % NREQ));
            cyc(4'b1111 & ~(4'b0001 << (i % NREQ)), 4'b0001 << (i % NREQ));
            check("t3_gap", 32'(gnt), 32'd0);
        end
        check("t3_phase", 32'(phase), 32'd5);

        // Walk to the last phase, then wrap
        rst = 1'b0;
        cyc('0, '0);
        rst = 1'b1;
        cyc(4'b0001, 4'b0000);
        repeat (4) cyc(4'b0001, 4'b0001);
        cyc(4'b0001, 4'b0000);
        repeat (2) cyc(4'b0001, 4'b0001);
        check("t4_phase6", 32'(phase), 32'd6);
        check("t4_boundary", 32'(boundary), 32'd1);
        check("t4_nowrap", 32'(wrap), 32'd0);
        cyc(4'b0001, 4'b0001);
        check("t4_phase0", 32'(phase), 32'd0);
        check("t4_wrap", 32'(wrap), 32'd1);
        cyc(4'b0000, 4'b0000);
        check("t4_wrap_once", 32'(wrap), 32'd0);

        // Non-owner step is ignored
        cyc(4'b0100, 4'b0000);
        check("t5_gnt", 32'(gnt), 32'b0100);
        cyc(4'b0100, 4'b0001);
        check("t5_phase", 32'(phase), 32'd0);
`ifdef STEP_ERR_EN
        check("t5_err", 32'(step_err), 32'd1);
`endif
        cyc(4'b0100, 4'b0000);
`ifdef STEP_ERR_EN
        check("t5_err_sticky", 32'(step_err), 32'd1);
`endif
        repeat (3) cyc(4'b0100, 4'b0100);
        check("t5_phase3", 32'(phase), 32'd3);
        check("t5_still_owner", 32'(gnt), 32'b0100);

        // Reset mid-grant
        rst = 1'b0;
        cyc(4'b0100, 4'b0100);
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_phase", 32'(phase), 32'd0);
        check("t6_wrap", 32'(wrap), 32'd0);
`ifdef STEP_ERR_EN
        check("t6_err", 32'(step_err), 32'd0);
`endif
        rst = 1'b1;

        // Mixed traffic checked by the model alone
        repeat (80) begin
            rnd_req  = NREQ'($urandom_range(0, 15));
            rnd_step = NREQ'($urandom_range(0, 15));
            cyc(rnd_req, rnd_step);
        end
        cyc('0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
